md_unit: RTL

Multiply/divide unit for the five-stage MIPS pipeline, sitting beside the ALU in the EXE stage and fed by the same forwarded operands. It executes MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency, owns the HI/LO architectural registers, and serves MTHI/MTLO writes. Its `busy` output feeds the hazard unit, which stalls any MD-class instruction in ID while an operation is pending. MFHI/MFLO read `hi`/`lo` combinationally in EXE.

---
 rtl/mdu_pkg.sv | 24 ++
 rtl/mdu_core.sv | 62 ++++++
 rtl/md_unit.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states, default latencies.
// The optional MADD op (code 6) is only accepted when MDU_MADD_EN is defined.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MADD  = 3'd6,
        OP_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int MUL_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF = 10;

endpackage

// File: rtl/mdu_core.sv
// Combinational datapath of the MD unit: 64-bit product, truncating divide,
// MADD accumulate sum and divide-by-zero flag, muxed into a {hi,lo} result by op.
module mdu_core
    import mdu_pkg::*;
(
    input  md_op_e      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic        signed_op;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] product;
    logic [63:0] madd_sum;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] safe_b;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    assign signed_op = (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD);

    // Low 64 bits of a product of sign-extended operands equal the signed product.
    assign a_ext    = {{32{a[31] & signed_op}}, a};
    assign b_ext    = {{32{b[31] & signed_op}}, b};
    assign product  = a_ext * b_ext;
    assign madd_sum = {hi, lo} + product;

    // Divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no overflow case.
    assign neg_a    = signed_op & a[31];
    assign neg_b    = signed_op & b[31];
    assign mag_a    = neg_a ? (32'd0 - a) : a;
    assign mag_b    = neg_b ? (32'd0 - b) : b;
    assign div_zero = (b == 32'd0);
    assign safe_b   = div_zero ? 32'd1 : mag_b;
    assign q_mag    = mag_a / safe_b;
    assign r_mag    = mag_a % safe_b;
    assign quot     = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
    assign rem      = neg_a ? (32'd0 - r_mag) : r_mag;

    always_comb begin
        res_hi = hi;
        res_lo = lo;
        case (op)
            OP_MULT, OP_MULTU: {res_hi, res_lo} = product;
            OP_DIV, OP_DIVU:   {res_hi, res_lo} = {rem, quot};
            OP_MADD:           {res_hi, res_lo} = madd_sum;
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle MIPS multiply/divide unit owning HI/LO; result is computed at issue,
// held in pending registers and committed after a fixed latency. Define MDU_MADD_EN to enable MADD.
module md_unit
    import mdu_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

`ifdef MDU_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

    md_op_e      op_e;
    md_state_e   state;
    md_state_e   state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [31:0] pend_hi;
    logic [31:0] pend_hi_next;
    logic [31:0] pend_lo;
    logic [31:0] pend_lo_next;
    logic        pend_skip;
    logic        pend_skip_next;
    logic [31:0] hi_next;
    logic [31:0] lo_next;
    logic        is_mul;
    logic        is_div;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        div_zero;

    assign op_e   = md_op_e'(op);
    assign is_mul = (op_e == OP_MULT) || (op_e == OP_MULTU) || (MADD_EN && (op_e == OP_MADD));
    assign is_div = (op_e == OP_DIV) || (op_e == OP_DIVU);
    assign busy   = (state == ST_RUN);

    mdu_core u_core (
        .op       (op_e),
        .a        (a),
        .b        (b),
        .hi       (hi),
        .lo       (lo),
        .res_hi   (res_hi),
        .res_lo   (res_lo),
        .div_zero (div_zero)
    );

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        pend_hi_next   = pend_hi;
        pend_lo_next   = pend_lo;
        pend_skip_next = pend_skip;
        hi_next        = hi;
        lo_next        = lo;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (is_mul || is_div) begin
                        state_next     = ST_RUN;
                        cnt_next       = is_div ? DIV_LOAD : MUL_LOAD;
                        pend_hi_next   = res_hi;
                        pend_lo_next   = res_lo;
                        pend_skip_next = is_div && div_zero;
                    end else if (op_e == OP_MTHI) begin
                        hi_next = a;
                    end else if (op_e == OP_MTLO) begin
                        lo_next = a;
                    end
                end
            end
            ST_RUN: begin
                // start is deliberately not examined here: issue while busy is dropped.
                if (cnt == '0) begin
                    state_next = ST_IDLE;
                    if (!pend_skip) begin
                        hi_next = pend_hi;
                        lo_next = pend_lo;
                    end
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            pend_hi   <= '0;
            pend_lo   <= '0;
            pend_skip <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            pend_hi   <= pend_hi_next;
            pend_lo   <= pend_lo_next;
            pend_skip <= pend_skip_next;
            hi        <= hi_next;
            lo        <= lo_next;
        end
    end

endmodule
